// File: rtl/psa_arb_pkg.sv
// rtl/psa_arb_pkg.sv - shared types and constants for the PSA arbiter block
package psa_arb_pkg;

  localparam int DATA_W = 16;
  localparam int NIB_W  = 4;
  localparam int NIB_N  = DATA_W / NIB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/psa_arbiter_adder.sv
// rtl/psa_arbiter_adder.sv - PSA_16bit partitioned adder: four independent nibble adds
module PSA_16bit
  import psa_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic [NIB_N-2:0]  carry
);

  // Only the lower three nibbles expose a carry; the top nibble's carry
  // would fall off the 16-bit result anyway and is never observable.
  for (genvar k = 0; k < NIB_N; k++) begin : g_nib
    if (k < NIB_N - 1) begin : g_lo
      assign {carry[k], sum[k*NIB_W +: NIB_W]} =
        {1'b0, a[k*NIB_W +: NIB_W]} + {1'b0, b[k*NIB_W +: NIB_W]};
    end else begin : g_hi
      assign sum[k*NIB_W +: NIB_W] = a[k*NIB_W +: NIB_W] + b[k*NIB_W +: NIB_W];
    end
  end

endmodule

// File: rtl/psa_arbiter.sv
// rtl/psa_arbiter.sv - two-requester arbiter around PSA_16bit; PSA_ARB_RR_EN selects round-robin
module psa_arbiter
  import psa_arb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [15:0]       req0_a,
  input  logic [15:0]       req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [15:0]       req1_a,
  input  logic [15:0]       req1_b,
  output logic              req1_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [15:0]       rsp_sum,
  output logic              rsp_error,
  output logic [CNT_W-1:0]  op_cnt
);

  state_t              state;
  state_t              state_nxt;
  req_id_t             grant;
  logic                idle_ok;
  logic                xfer;
  logic                rsp_hs;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   psa_sum;
  logic [NIB_N-2:0]    psa_carry;

`ifdef PSA_ARB_RR_EN
  req_id_t last_served;

  // On a tie the requester not served last wins; a lone requester always wins.
  assign grant = (req0_valid && req1_valid) ? ~last_served : ~req0_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_served <= 1'b1;
    end else if (xfer) begin
      last_served <= grant;
    end
  end
`else
  assign grant = ~req0_valid;
`endif

  // Gating on rst_n keeps both readys low for the whole reset, not just after it.
  assign idle_ok    = rst_n && (state == IDLE);
  assign req0_ready = idle_ok && req0_valid && !grant;
  assign req1_ready = idle_ok && req1_valid && grant;
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign rsp_valid  = (state == RESP);
  assign rsp_hs     = rsp_valid && rsp_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer)   state_nxt = EXEC;
      EXEC:                state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  PSA_16bit u_psa (
    .a     (op_a),
    .b     (op_b),
    .sum   (psa_sum),
    .carry (psa_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_error <= 1'b0;
      op_cnt    <= '0;
    end else begin
      if (xfer) begin
        op_a   <= grant ? req1_a : req0_a;
        op_b   <= grant ? req1_b : req0_b;
        rsp_id <= grant;
      end
      if (state == EXEC) begin
        rsp_sum   <= psa_sum;
        rsp_error <= |psa_carry;
      end
      if (rsp_hs) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
    end
  end

endmodule
